lcd_init_sequencer: RTL and testbench

//  Upstream stage of the LCD text writer. Runs the HD44780 8-bit power-on command sequence on the

---
 rtl/lcd_init_sequencer_if.sv | 29 ++
 rtl/lcd_init_sequencer.sv | 153 +++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_init_sequencer_if.sv
// Purpose: LCD bus plus init-status handshake between the HD44780 init sequencer
//          and the downstream writer / top-level bus mux.
// Signals:
//   enable       LCD E strobe (LCD latches on the falling edge)
//   rs, rw       register select / read-write, both held at 0 by the sequencer
//   dados[7:0]   LCD DB7..DB0
//   inicializado sequence complete, bus free for the writer
//   ocupado      sequence running (always !inicializado)
//   reinit       one-cycle request to replay the command list
// Modports: master = sequencer side, slave = consumer side.
interface lcd_init_sequencer_if;
  logic       enable;
  logic       rs;
  logic       rw;
  logic [7:0] dados;
  logic       inicializado;
  logic       ocupado;
  logic       reinit;

  modport master (
    output enable, rs, rw, dados, inicializado, ocupado,
    input  reinit
  );

  modport slave (
    input  enable, rs, rw, dados, inicializado, ocupado,
    output reinit
  );
endinterface

// File: rtl/lcd_init_sequencer.sv
// Purpose: runs the HD44780 8-bit power-on command list (30,30,30,38,08,01,06,0C)
//          on the shared LCD bus, then raises inicializado. A reinit request in
//          DONE replays the list without the power-on wait.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     lcd_init_sequencer_if.master (LCD strobe/data out, status out, reinit in)
module lcd_init_sequencer #(
  parameter int unsigned T_POWERON = 1500000,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_LONG    = 205000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lcd_init_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    ST_POWERON,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               en_q;
  logic               rs_q;
  logic               rw_q;
  logic [7:0]         dados_q;
  logic               init_q;
  logic               busy_q;

  logic               wait_last_c;

  // Command list in issue order.
  function automatic logic [7:0] cmd_rom(input logic [IDX_W-1:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h30;
      3'd1:    c = 8'h30;
      3'd2:    c = 8'h30;
      3'd3:    c = 8'h38;
      3'd4:    c = 8'h08;
      3'd5:    c = 8'h01;
      3'd6:    c = 8'h06;
      default: c = 8'h0C;
    endcase
    return c;
  endfunction

  // Last cycle of the post-command wait; the first 0x30 and Clear need the long wait.
  always_comb begin
    wait_last_c = 1'b0;
    if (idx_q == 3'd0 || idx_q == 3'd5) begin
      wait_last_c = (cnt_q == CNT_W'(T_LONG - 1));
    end else begin
      wait_last_c = (cnt_q == CNT_W'(T_CMD - 1));
    end
  end

  // Sequencer FSM; outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_POWERON;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      dados_q <= 8'h00;
      init_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_POWERON: begin
          if (cnt_q == CNT_W'(T_POWERON - 1)) begin
            state_q <= ST_SETUP;
            cnt_q   <= '0;
            dados_q <= cmd_rom(idx_q);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Data was presented on entry; one cycle of address setup before E rises.
        ST_SETUP: begin
          state_q <= ST_PULSE;
          cnt_q   <= '0;
          en_q    <= 1'b1;
        end

        ST_PULSE: begin
          if (cnt_q == CNT_W'(T_PULSE - 1)) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Data stays on the bus through the wait to cover LCD hold time.
        ST_WAIT: begin
          if (wait_last_c) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= ST_DONE;
              dados_q <= 8'h00;
              init_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_SETUP;
              idx_q   <= idx_q + IDX_W'(1);
              dados_q <= cmd_rom(idx_q + IDX_W'(1));
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (bus.reinit) begin
            state_q <= ST_SETUP;
            idx_q   <= '0;
            dados_q <= cmd_rom(IDX_W'(0));
            init_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_POWERON;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.enable       = en_q;
  assign bus.rs           = rs_q;
  assign bus.rw           = rw_q;
  assign bus.dados        = dados_q;
  assign bus.inicializado = init_q;
  assign bus.ocupado      = busy_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Purpose: randomized self-checking bench for lcd_init_sequencer. A timeline
//          reference computes the expected bus from the command list and delays.
module tb_lcd_init_sequencer;

  localparam int TPO   = 20;
  localparam int TPU   = 2;
  localparam int TCMD  = 5;
  localparam int TLONG = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_init_sequencer_if bus ();

  lcd_init_sequencer #(
    .T_POWERON (TPO),
    .T_PULSE   (TPU),
    .T_CMD     (TCMD),
    .T_LONG    (TLONG)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_tb [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  int n_checks = 0;
  int n_pass   = 0;
  int n_edge   = 0;   // rising edges since reset release
  int origin   = TPO; // edge at which the current command list starts (SETUP of cmd 0)
  int first_rise = -1;
  int first_done = -1;
  logic prev_en  = 1'b0;
  logic prev_ini = 1'b0;

  function automatic int wait_of(input int i);
    return (i == 0 || i == 5) ? TLONG : TCMD;
  endfunction

  function automatic int run_len();
    int s = 0;
    for (int i = 0; i < 8; i++) s += 1 + TPU + wait_of(i);
    return s;
  endfunction

  // Expected bus t edges after the list starts; t < 0 is the power-on idle.
  task automatic expect_at(input int t, output logic en, output logic [7:0] d,
                           output logic done);
    en   = 1'b0;
    d    = 8'h00;
    done = 1'b0;
    if (t < 0) return;
    for (int i = 0; i < 8; i++) begin
      int dur;
      dur = 1 + TPU + wait_of(i);
      if (t < dur) begin
        en = (t >= 1 && t <= TPU);
        d  = rom_tb[i];
        return;
      end
      t -= dur;
    end
    done = 1'b1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
  endtask

  task automatic check_outputs();
    logic en, done;
    logic [7:0] d;
    expect_at(n_edge - origin, en, d, done);
    check_eq("enable",       32'(bus.enable),       32'(en));
    check_eq("dados",        32'(bus.dados),        32'(d));
    check_eq("inicializado", 32'(bus.inicializado), 32'(done));
    check_eq("ocupado",      32'(bus.ocupado),      32'(!done));
    check_eq("rs",           32'(bus.rs),           32'(0));
    check_eq("rw",           32'(bus.rw),           32'(0));
  endtask

  // Called at a falling edge: drive reinit, advance one cycle, update model, check.
  task automatic step(input logic r);
    logic en_p, done_p, smp;
    logic [7:0] d_p;
    bus.reinit = r;
    expect_at(n_edge - origin, en_p, d_p, done_p);
    @(posedge clk);
    smp = bus.reinit;
    n_edge++;
    if (smp && done_p) origin = n_edge;
    #1;
    check_outputs();
    if (bus.enable && !prev_en && first_rise < 0) first_rise = n_edge;
    if (bus.inicializado && !prev_ini && first_done < 0) first_done = n_edge;
    prev_en  = bus.enable;
    prev_ini = bus.inicializado;
    @(negedge clk);
  endtask

  // Called at a falling edge: async reset mid-cycle, hold, release on a falling edge.
  task automatic apply_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_enable",  32'(bus.enable),       32'(0));
    check_eq("rst_dados",   32'(bus.dados),        32'(0));
    check_eq("rst_init",    32'(bus.inicializado), 32'(0));
    check_eq("rst_ocupado", 32'(bus.ocupado),      32'(1));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.reinit = 1'b0;
    rst_n      = 1'b1;
    n_edge     = 0;
    origin     = TPO;
    first_rise = -1;
    first_done = -1;
    prev_en    = 1'b0;
    prev_ini   = 1'b0;
    check_outputs();
  endtask

  initial begin
    bus.reinit = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Power-on run; a reinit during the WAIT of cmd 2 must be ignored.
    for (int k = 0; k < 110; k++) step(n_edge == 44);
    check_eq("first_rise", 32'(first_rise), 32'(TPO + 1));
    check_eq("done_edge",  32'(first_done), 32'(TPO + run_len()));

    // Reinit from DONE replays the list without the power-on wait.
    first_rise = -1;
    first_done = -1;
    step(1'b1);
    begin
      int pulse_edge;
      pulse_edge = n_edge;
      for (int k = 0; k < 85; k++) step(1'b0);
      check_eq("reinit_rise", 32'(first_rise), 32'(pulse_edge + 1));
      check_eq("reinit_done", 32'(first_done), 32'(pulse_edge + run_len()));
    end

    // Reset in the middle of cmd 3's enable pulse, then a full restart.
    apply_reset(3);
    for (int k = 0; k < 50; k++) step(1'b0);
    check_eq("pulse_cmd3", 32'(bus.enable), 32'(1));
    apply_reset(2);
    for (int k = 0; k < 100; k++) step(1'b0);

    // Randomized reinit traffic and resets at random points.
    for (int it = 0; it < 8; it++) begin
      int len;
      len = int'($urandom_range(20, 160));
      for (int k = 0; k < len; k++) step($urandom_range(0, 19) == 0);
      apply_reset(int'($urandom_range(1, 4)));
    end
    for (int k = 0; k < 110; k++) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
